// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit (master) and InstMem (slave).
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack bus and buffers {pc, inst} in a prefetch FIFO.
// Optional macro FETCH_MISALIGN_TRAP_EN: misaligned redirect targets raise misalign and halt fetch.
module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  fetch_unit_if.master           imem,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  input  logic                   stall,
  output logic                   if_valid,
  output logic [31:0]            if_pc,
  output logic [31:0]            if_inst,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   misalign
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {FETCH, DISCARD, HALT} state_t;
`else
  typedef enum logic {FETCH, DISCARD} state_t;
`endif

  state_t          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     pend_pc_q, pend_pc_d;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [31:0]     pc_mem   [DEPTH];
  logic [31:0]     inst_mem [DEPTH];
  logic            req, push, pop;
  logic [31:0]     tgt;
  logic            tgt_mis;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q, pend_halt_q;
  assign tgt      = redirect_pc;
  assign tgt_mis  = |redirect_pc[1:0];
  assign misalign = misalign_q;
`else
  assign tgt      = redirect_pc & ~32'h3;
  assign tgt_mis  = 1'b0;
  assign misalign = 1'b0;
`endif

  assign if_valid       = (count_q != '0);
  assign if_pc          = if_valid ? pc_mem[rd_ptr_q]   : '0;
  assign if_inst        = if_valid ? inst_mem[rd_ptr_q] : '0;
  assign fifo_count     = count_q;
  assign pop            = if_valid & ~stall & ~redirect;
  // Request is masked during reset so the bus is idle while rst is low.
  assign imem.imem_req  = req & rst;
  assign imem.imem_addr = fetch_pc_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    req        = 1'b0;
    push       = 1'b0;
    case (state_q)
      FETCH:   req = (count_q < CW'(DEPTH));
      DISCARD: req = 1'b1;
      default: req = 1'b0;
    endcase
    if (redirect) begin
      // An outstanding handshake must still complete, so its data is discarded later.
      if (req && !imem.imem_ack) begin
        pend_pc_d = tgt;
        state_d   = DISCARD;
      end else begin
        state_d = FETCH;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (tgt_mis) state_d = HALT;
        else         fetch_pc_d = tgt;
`else
        fetch_pc_d = tgt;
`endif
      end
    end else begin
      case (state_q)
        FETCH: begin
          if (req && imem.imem_ack) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
        end
        DISCARD: begin
          if (imem.imem_ack) begin
            state_d    = FETCH;
            fetch_pc_d = pend_pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (pend_halt_q) begin
              state_d    = HALT;
              fetch_pc_d = fetch_pc_q;
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      pend_pc_q  <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
      if (redirect) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        count_q <= count_q + CW'(push) - CW'(pop);
      end
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misalign_q  <= 1'b0;
      pend_halt_q <= 1'b0;
    end else if (redirect) begin
      misalign_q <= tgt_mis;
      if (req && !imem.imem_ack) pend_halt_q <= tgt_mis;
    end
  end
`endif

  // FIFO storage carries data only; occupancy is tracked by the control registers above.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= fetch_pc_q;
      inst_mem[wr_ptr_q] <= imem.imem_rdata;
    end
  end
endmodule
